// File: rtl/booth_pkg.sv
// Shared types for the Booth multiplier: FSM state encoding and the
// per-step add/subtract decision derived from {Q[0], q_m1}.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_Y,
    CALC,
    OUT_HI,
    OUT_LO
  } state_t;

  typedef enum logic [1:0] {
    NOP,
    ADD,
    SUB
  } booth_op_t;

  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    case (pair)
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mult_ctrl.sv
// Sequencer for the Booth multiplier: state machine, step counter and the
// registered done/out_lo/busy flags.
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   long_op,
  output state_t state,
  output logic   load_m,
  output logic   load_q,
  output logic   step,
  output logic   last_step,
  output logic   done,
  output logic   out_lo,
  output logic   busy
);

  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] STEPS = CW'(W);

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic            done_reg;
  logic            out_lo_reg;
  logic            busy_reg;

  assign state     = state_reg;
  assign load_m    = (state_reg == IDLE) && start;
  assign load_q    = (state_reg == LOAD_Y);
  assign step      = (state_reg == CALC);
  assign last_step = step && (count_reg == CW'(1));
  assign done      = done_reg;
  assign out_lo    = out_lo_reg;
  assign busy      = busy_reg;

  // Flags are updated on the transition into each state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      done_reg   <= 1'b0;
      out_lo_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= LOAD_Y;
            busy_reg  <= 1'b1;
          end
        end
        LOAD_Y: begin
          count_reg <= STEPS + {{(CW-1){1'b0}}, long_op};
          state_reg <= CALC;
        end
        CALC: begin
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= OUT_HI;
            done_reg  <= 1'b1;
          end
        end
        OUT_HI: begin
          state_reg  <= OUT_LO;
          out_lo_reg <= 1'b1;
        end
        OUT_LO: begin
          state_reg  <= IDLE;
          done_reg   <= 1'b0;
          out_lo_reg <= 1'b0;
          busy_reg   <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          done_reg   <= 1'b0;
          out_lo_reg <= 1'b0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/booth_mult_param.sv
// Radix-2 Booth multiplier, W-bit operands in, 2W-bit product out as two words.
// Define BOOTH_UNSIGNED_EN to add the is_signed port for unsigned operation.
module booth_mult_param
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] inbus,
`ifdef BOOTH_UNSIGNED_EN
  input  logic         is_signed,
`endif
  output logic [W-1:0] outbus,
  output logic         done,
  output logic         out_lo,
  output logic         busy
);

  state_t    state;
  logic      load_m, load_q, step, last_step;
  logic      unsigned_now;
  logic      unsigned_op;

  logic [W:0]   a_reg, m_reg, q_reg;
  logic         qm1_reg;
  logic [W-1:0] outbus_reg;

  booth_op_t    op;
  logic [W:0]   sum;
  logic [W:0]   a_shift, q_shift;
  logic [W-1:0] hi_shift, lo_now;

  function automatic logic [W:0] extend(input logic [W-1:0] v, input logic zero_ext);
    return {(zero_ext ? 1'b0 : v[W-1]), v};
  endfunction

`ifdef BOOTH_UNSIGNED_EN
  logic unsigned_reg;
  assign unsigned_now = ~is_signed;
  assign unsigned_op  = unsigned_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      unsigned_reg <= 1'b0;
    end else if (load_m) begin
      unsigned_reg <= ~is_signed;
    end
  end
`else
  assign unsigned_now = 1'b0;
  assign unsigned_op  = 1'b0;
`endif

  booth_mult_ctrl #(.W(W)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .long_op   (unsigned_op),
    .state     (state),
    .load_m    (load_m),
    .load_q    (load_q),
    .step      (step),
    .last_step (last_step),
    .done      (done),
    .out_lo    (out_lo),
    .busy      (busy)
  );

  assign op = booth_decode({q_reg[0], qm1_reg});

  always_comb begin
    sum = a_reg;
    case (op)
      ADD:     sum = a_reg + m_reg;
      SUB:     sum = a_reg - m_reg;
      default: sum = a_reg;
    endcase
  end

  assign a_shift = {sum[W], sum[W:1]};
  assign q_shift = {sum[0], q_reg[W:1]};

  // Unsigned runs one extra step, so the product sits one bit further down
  // in {A,Q}; signed mode leaves the unconsumed sign copy in Q[0].
  assign hi_shift = unsigned_op ? {a_shift[W-2:0], q_shift[W]} : a_shift[W-1:0];
  assign lo_now   = unsigned_op ? q_reg[W-1:0] : q_reg[W:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      m_reg      <= '0;
      q_reg      <= '0;
      qm1_reg    <= 1'b0;
      outbus_reg <= '0;
    end else begin
      if (load_m) begin
        m_reg <= extend(inbus, unsigned_now);
      end
      if (load_q) begin
        q_reg   <= extend(inbus, unsigned_op);
        a_reg   <= '0;
        qm1_reg <= 1'b0;
      end
      if (step) begin
        a_reg   <= a_shift;
        q_reg   <= q_shift;
        qm1_reg <= q_reg[0];
      end
      if (last_step) begin
        outbus_reg <= hi_shift;
      end else if (state == OUT_HI) begin
        outbus_reg <= lo_now;
      end else begin
        outbus_reg <= '0;
      end
    end
  end

  assign outbus = outbus_reg;

endmodule

// File: tb/tb_booth_mult_param.sv
// Directed bench for booth_mult_param at W=8; build with BOOTH_UNSIGNED_EN
// defined to also exercise unsigned mode.
module tb_booth_mult_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] inbus = 8'h00;
`ifdef BOOTH_UNSIGNED_EN
  logic       is_signed = 1'b1;
`endif
  logic [7:0] outbus;
  logic       done, out_lo, busy;

  int checks = 0;
  int failures = 0;

  booth_mult_param #(.W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .inbus  (inbus),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed (is_signed),
`endif
    .outbus (outbus),
    .done   (done),
    .out_lo (out_lo),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation starting in the current cycle (cycle 0) and observes
  // ncyc cycles. Optional start pulses and a reset pulse are injected at the
  // given cycle numbers (-1 disables).
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic sgn,
                        input int ncyc, input int glitch_a, input int glitch_b,
                        input int rst_cyc,
                        output logic [7:0] hi, output logic [7:0] lo,
                        output int hi_cyc, output int lo_cyc,
                        output int done_cnt, output int stray, output int busy_gap);
    hi = 8'h00; lo = 8'h00; hi_cyc = -1; lo_cyc = -1;
    done_cnt = 0; stray = 0; busy_gap = 0;
    rst = 1'b0;
    start = 1'b1;
    inbus = x;
`ifdef BOOTH_UNSIGNED_EN
    is_signed = sgn;
`else
    if (sgn !== 1'b1) $display("note: unsigned request ignored in signed-only build");
`endif
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (done) begin
        done_cnt++;
        if (!out_lo) begin
          hi = outbus; hi_cyc = c;
        end else begin
          lo = outbus; lo_cyc = c;
        end
      end else if (outbus !== 8'h00 || out_lo !== 1'b0) begin
        stray++;
      end
      if (hi_cyc < 0 && rst_cyc < 0 && c <= 9 && busy !== 1'b1) busy_gap++;
      start = (c == glitch_a) || (c == glitch_b);
      inbus = (c == 1) ? y : 8'hA5;
      rst   = (c == rst_cyc);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [7:0] hi, input logic [7:0] lo,
                          input int hi_cyc, input int lo_cyc, input int done_cnt,
                          input int stray, input int busy_gap,
                          input logic [7:0] exp_hi, input logic [7:0] exp_lo, input int exp_cyc);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      failures++;
      $display("FAIL %s words: got %02h_%02h expected %02h_%02h", name, hi, lo, exp_hi, exp_lo);
    end
    checks++;
    if (hi_cyc != exp_cyc || lo_cyc != exp_cyc + 1) begin
      failures++;
      $display("FAIL %s timing: hi@%0d lo@%0d expected hi@%0d lo@%0d", name, hi_cyc, lo_cyc, exp_cyc, exp_cyc + 1);
    end
    checks++;
    if (done_cnt != 2 || stray != 0 || busy_gap != 0) begin
      failures++;
      $display("FAIL %s framing: done_cycles=%0d stray=%0d busy_gap=%0d expected 2/0/0", name, done_cnt, stray, busy_gap);
    end
    $display("op %s: hi=%02h lo=%02h hi_cyc=%0d done_cycles=%0d", name, hi, lo, hi_cyc, done_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; inbus = 8'hFF;
    tick(); tick();
    checks++;
    if (outbus !== 8'h00) begin failures++; $display("FAIL reset_outbus: got %02h expected 00", outbus); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (out_lo !== 1'b0) begin failures++; $display("FAIL reset_out_lo: got %b expected 0", out_lo); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    $display("reset: outbus=%02h done=%b out_lo=%b busy=%b", outbus, done, out_lo, busy);
  endtask

  task automatic test_signed();
    logic [7:0] hi, lo; int hc, lc, dc, st, bg;
    run_op(8'h03, 8'hFB, 1'b1, 14, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("3x-5", hi, lo, hc, lc, dc, st, bg, 8'hFF, 8'hF1, 10);
    run_op(8'h7F, 8'h7F, 1'b1, 14, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("127x127", hi, lo, hc, lc, dc, st, bg, 8'h3F, 8'h01, 10);
    run_op(8'hFF, 8'hFF, 1'b1, 14, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("-1x-1", hi, lo, hc, lc, dc, st, bg, 8'h00, 8'h01, 10);
  endtask

  task automatic test_corners();
    logic [7:0] hi, lo; int hc, lc, dc, st, bg;
    run_op(8'h80, 8'h80, 1'b1, 14, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("-128x-128", hi, lo, hc, lc, dc, st, bg, 8'h40, 8'h00, 10);
    run_op(8'h7F, 8'h00, 1'b1, 14, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("127x0", hi, lo, hc, lc, dc, st, bg, 8'h00, 8'h00, 10);
    run_op(8'h80, 8'h7F, 1'b1, 14, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("-128x127", hi, lo, hc, lc, dc, st, bg, 8'hC0, 8'h80, 10);
  endtask

  task automatic test_start_ignored();
    logic [7:0] hi, lo; int hc, lc, dc, st, bg;
    run_op(8'h03, 8'hFB, 1'b1, 25, 3, 5, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("busy_start", hi, lo, hc, lc, dc, st, bg, 8'hFF, 8'hF1, 10);
    run_op(8'h05, 8'h06, 1'b1, 25, 11, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("out_lo_start", hi, lo, hc, lc, dc, st, bg, 8'h00, 8'h1E, 10);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ignored_start_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] hi, lo; int hc, lc, dc, st, bg;
    run_op(8'h7F, 8'h7F, 1'b1, 20, -1, -1, 6, hi, lo, hc, lc, dc, st, bg);
    checks++;
    if (dc != 0 || st != 0) begin
      failures++;
      $display("FAIL mid_reset: done_cycles=%0d stray=%0d expected 0/0", dc, st);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    $display("mid_reset: done_cycles=%0d busy=%b", dc, busy);
    run_op(8'h02, 8'h03, 1'b1, 14, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("after_reset_2x3", hi, lo, hc, lc, dc, st, bg, 8'h00, 8'h06, 10);
  endtask

  task automatic test_back_to_back();
    logic [7:0] hi, lo; int hc, lc, dc, st, bg;
    run_op(8'hF6, 8'h0C, 1'b1, 12, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("b2b_first", hi, lo, hc, lc, dc, st, bg, 8'hFF, 8'h88, 10);
    run_op(8'h11, 8'h11, 1'b1, 14, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("b2b_second", hi, lo, hc, lc, dc, st, bg, 8'h01, 8'h21, 10);
  endtask

`ifdef BOOTH_UNSIGNED_EN
  task automatic test_unsigned();
    logic [7:0] hi, lo; int hc, lc, dc, st, bg;
    run_op(8'hFF, 8'hFF, 1'b0, 16, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("u255x255", hi, lo, hc, lc, dc, st, bg, 8'hFE, 8'h01, 11);
    run_op(8'h80, 8'h02, 1'b0, 16, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("u128x2", hi, lo, hc, lc, dc, st, bg, 8'h01, 8'h00, 11);
    run_op(8'hFF, 8'hFF, 1'b1, 16, -1, -1, -1, hi, lo, hc, lc, dc, st, bg);
    check_op("s-1x-1", hi, lo, hc, lc, dc, st, bg, 8'h00, 8'h01, 10);
  endtask
`endif

  initial begin
    test_reset();
    test_signed();
    test_corners();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef BOOTH_UNSIGNED_EN
    test_unsigned();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
